// File: rtl/sdram_init_refresh_if.sv
// Bus between the SDRAM init/refresh sequencer and the main controller.
// The sequencer drives the SDRAM command bus during init and the refresh
// request/pending status; the controller answers refresh requests on REF_ACK.
interface sdram_init_refresh_if #(
  parameter int ADDR_W = 13
);
  logic              CKE;
  logic [3:0]        CMD;
  logic [ADDR_W-1:0] ADDR;
  logic [1:0]        BA;
  logic              INIT_DONE;
  logic              REF_REQ;
  logic              REF_ACK;
  logic [3:0]        REF_PENDING;
  logic              REF_OVERFLOW;

  modport master (
    output CKE, CMD, ADDR, BA, INIT_DONE, REF_REQ, REF_PENDING, REF_OVERFLOW,
    input  REF_ACK
  );

  modport slave (
    input  CKE, CMD, ADDR, BA, INIT_DONE, REF_REQ, REF_PENDING, REF_OVERFLOW,
    output REF_ACK
  );
endinterface

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up initialisation sequencer and periodic refresh scheduler.
// Runs the JEDEC start-up sequence (inhibit wait, PRECHARGE ALL, N x AUTO
// REFRESH, LOAD MODE), then hands the bus to the controller and tracks owed
// refreshes through a REQ/ACK handshake. All outputs are registered: every
// output flop is loaded from the value computed for the upcoming cycle's state.
module sdram_init_refresh #(
  parameter int              T_POWERUP    = 20000,
  parameter int              T_RP         = 3,
  parameter int              T_RFC        = 7,
  parameter int              T_MRD        = 2,
  parameter int              INIT_REFS    = 8,
  parameter int              ADDR_W       = 13,
  parameter logic [ADDR_W-1:0] MODE_REG   = ADDR_W'(13'h0030),
  parameter int              REF_INTERVAL = 780,
  parameter int              MAX_PENDING  = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  sdram_init_refresh_if.master   bus
);

  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  typedef enum logic [2:0] {
    POWERUP, PRECH, WAIT_RP, REF, WAIT_RFC, MRS, WAIT_MRD, IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;      // cycles spent in the current timed state
  logic [3:0]        refs_q, refs_d;    // AUTO REFRESH commands issued during init
  logic [15:0]       tmr_q, tmr_d;      // refresh interval down-counter
  logic              cke_q, cke_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        ba_q, ba_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic [3:0]        pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              tick_s;
  logic              ack_s;

  // Next-state, next-output and refresh bookkeeping for the coming cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    refs_d  = refs_q;
    tmr_d   = tmr_q;
    cke_d   = 1'b1;
    cmd_d   = CMD_NOP;
    addr_d  = '0;
    ba_d    = 2'b00;
    done_d  = done_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    // The reset cycle counts as zero elapsed cycles, so POWERUP spans
    // exactly T_POWERUP cycles after RESET drops.
    case (state_q)
      POWERUP: begin
        if (cnt_q >= 16'(T_POWERUP)) begin
          state_d = PRECH;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PRECH: begin
        if (T_RP == 1) begin
          state_d = REF;
        end else begin
          state_d = WAIT_RP;
        end
        cnt_d = 16'd1;
      end
      WAIT_RP: begin
        if (cnt_q >= 16'(T_RP - 1)) begin
          state_d = REF;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      REF, WAIT_RFC: begin
        if ((state_q == REF && T_RFC == 1) ||
            (state_q == WAIT_RFC && cnt_q >= 16'(T_RFC - 1))) begin
          state_d = (refs_q < 4'(INIT_REFS)) ? REF : MRS;
        end else if (state_q == REF) begin
          state_d = WAIT_RFC;
          cnt_d   = 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      MRS: begin
        if (T_MRD == 1) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_MRD;
        end
        cnt_d = 16'd1;
      end
      WAIT_MRD: begin
        if (cnt_q >= 16'(T_MRD - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = POWERUP;
        cnt_d   = 16'd0;
      end
    endcase

    // Bus drive for the state being entered.
    case (state_d)
      POWERUP: cmd_d = CMD_INHIBIT;
      PRECH: begin
        cmd_d      = CMD_PRECHARGE;
        addr_d[10] = 1'b1;
      end
      REF: begin
        cmd_d  = CMD_AUTO_REF;
        refs_d = refs_q + 4'd1;
      end
      MRS: begin
        cmd_d  = CMD_LOAD_MODE;
        addr_d = MODE_REG;
      end
      IDLE:    done_d = 1'b1;
      default: cmd_d = CMD_NOP;
    endcase

    // Refresh interval timer: loaded on IDLE entry, reloads after reaching 0.
    tick_s = (state_q == IDLE) && (tmr_q == 16'd0);
    if (state_d == IDLE && state_q != IDLE) begin
      tmr_d = 16'(REF_INTERVAL - 1);
    end else if (state_q == IDLE) begin
      tmr_d = tick_s ? 16'(REF_INTERVAL - 1) : (tmr_q - 16'd1);
    end else begin
      tmr_d = tmr_q;
    end

    // Owed-refresh count; an ACK only counts while a request is visible.
    ack_s = bus.REF_ACK && req_q;
    if (tick_s && !ack_s) begin
      if (pend_q == 4'(MAX_PENDING)) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 4'd1;
      end
    end else if (ack_s && !tick_s) begin
      pend_d = pend_q - 4'd1;
    end else begin
      pend_d = pend_q;
    end

    req_d = done_d && (pend_d != 4'd0);
  end

  // State, counters and registered outputs; RESET restarts from POWERUP.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= POWERUP;
      cnt_q   <= 16'd0;
      refs_q  <= 4'd0;
      tmr_q   <= 16'd0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_INHIBIT;
      addr_q  <= '0;
      ba_q    <= 2'b00;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      pend_q  <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      refs_q  <= refs_d;
      tmr_q   <= tmr_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      done_q  <= done_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.CKE          = cke_q;
  assign bus.CMD          = cmd_q;
  assign bus.ADDR         = addr_q;
  assign bus.BA           = ba_q;
  assign bus.INIT_DONE    = done_q;
  assign bus.REF_REQ      = req_q;
  assign bus.REF_PENDING  = pend_q;
  assign bus.REF_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh. Instance A uses the short-timing
// parameter set; instance B is identical except INIT_REFS=1 and T_RP=1.
// Cycle n is the clock period following the n-th rising edge after RESET
// drops; outputs are sampled and inputs changed on the falling edge.
module tb_sdram_init_refresh;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = -1;

  always #5 CLK = ~CLK;

  sdram_init_refresh_if #(.ADDR_W(13)) if_a ();
  sdram_init_refresh_if #(.ADDR_W(13)) if_b ();

  sdram_init_refresh #(
    .T_POWERUP(10), .T_RP(2), .T_RFC(3), .T_MRD(2), .INIT_REFS(2),
    .ADDR_W(13), .MODE_REG(13'h0030), .REF_INTERVAL(5), .MAX_PENDING(3)
  ) dut_a (.CLK(CLK), .RESET(RESET), .bus(if_a));

  sdram_init_refresh #(
    .T_POWERUP(10), .T_RP(1), .T_RFC(3), .T_MRD(2), .INIT_REFS(1),
    .ADDR_W(13), .MODE_REG(13'h0030), .REF_INTERVAL(5), .MAX_PENDING(3)
  ) dut_b (.CLK(CLK), .RESET(RESET), .bus(if_b));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    if_a.REF_ACK = 1'b0;
    if_b.REF_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_cke", 16'(if_a.CKE), 16'h0);
    chk("rst_cmd", 16'(if_a.CMD), 16'hF);
    chk("rst_addr", 16'(if_a.ADDR), 16'h0);
    chk("rst_ba", 16'(if_a.BA), 16'h0);
    chk("rst_done", 16'(if_a.INIT_DONE), 16'h0);
    chk("rst_req", 16'(if_a.REF_REQ), 16'h0);
    chk("rst_pend", 16'(if_a.REF_PENDING), 16'h0);
    chk("rst_ovf", 16'(if_a.REF_OVERFLOW), 16'h0);
    RESET = 1'b0;
    cyc = -1;
  endtask

  initial begin
    logic [3:0]  cmd_a, cmd_b;
    logic [15:0] addr_a, addr_b;
    logic [3:0]  pend_e;

    // Test 1 and 6: init sequence on both instances
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      step();
      case (cyc)
        10: begin cmd_a = 4'h2; addr_a = 16'h0400; end
        12, 15: begin cmd_a = 4'h1; addr_a = 16'h0000; end
        18: begin cmd_a = 4'h0; addr_a = 16'h0030; end
        default: begin cmd_a = (cyc < 10) ? 4'hF : 4'h7; addr_a = 16'h0000; end
      endcase
      case (cyc)
        10: begin cmd_b = 4'h2; addr_b = 16'h0400; end
        11: begin cmd_b = 4'h1; addr_b = 16'h0000; end
        14: begin cmd_b = 4'h0; addr_b = 16'h0030; end
        default: begin cmd_b = (cyc < 10) ? 4'hF : 4'h7; addr_b = 16'h0000; end
      endcase
      chk("a_cmd", 16'(if_a.CMD), 16'(cmd_a));
      chk("a_addr", 16'(if_a.ADDR), addr_a);
      chk("a_ba", 16'(if_a.BA), 16'h0);
      chk("a_cke", 16'(if_a.CKE), 16'h1);
      chk("a_done", 16'(if_a.INIT_DONE), (cyc >= 20) ? 16'h1 : 16'h0);
      chk("b_cmd", 16'(if_b.CMD), 16'(cmd_b));
      chk("b_addr", 16'(if_b.ADDR), addr_b);
      chk("b_done", 16'(if_b.INIT_DONE), (cyc >= 16) ? 16'h1 : 16'h0);
    end

    // Test 2: no ACK, pending climbs to saturation then overflow is flagged
    for (int c = 21; c <= 45; c++) begin
      step();
      if (cyc >= 35) pend_e = 4'd3;
      else if (cyc >= 30) pend_e = 4'd2;
      else if (cyc >= 25) pend_e = 4'd1;
      else pend_e = 4'd0;
      chk("t2_pend", 16'(if_a.REF_PENDING), 16'(pend_e));
      chk("t2_req", 16'(if_a.REF_REQ), (pend_e != 4'd0) ? 16'h1 : 16'h0);
      chk("t2_ovf", 16'(if_a.REF_OVERFLOW), (cyc >= 40) ? 16'h1 : 16'h0);
      chk("t2_cmd", 16'(if_a.CMD), 16'h7);
    end

    // Test 3: ACK without request ignored; held ACK consumes only one
    do_reset();
    run_to(24);
    chk("t3_pend24", 16'(if_a.REF_PENDING), 16'h0);
    if_a.REF_ACK = 1'b1;
    step();
    chk("t3_pend25", 16'(if_a.REF_PENDING), 16'h1);
    chk("t3_req25", 16'(if_a.REF_REQ), 16'h1);
    step();
    chk("t3_pend26", 16'(if_a.REF_PENDING), 16'h0);
    chk("t3_req26", 16'(if_a.REF_REQ), 16'h0);
    step();
    chk("t3_pend27", 16'(if_a.REF_PENDING), 16'h0);
    if_a.REF_ACK = 1'b0;
    step();
    chk("t3_pend28", 16'(if_a.REF_PENDING), 16'h0);
    run_to(30);
    chk("t3_pend30", 16'(if_a.REF_PENDING), 16'h1);
    chk("t3_ovf", 16'(if_a.REF_OVERFLOW), 16'h0);

    // Test 4: ACK coincident with a tick leaves the count unchanged
    do_reset();
    run_to(28);
    chk("t4_pend28", 16'(if_a.REF_PENDING), 16'h1);
    step();
    chk("t4_pend29", 16'(if_a.REF_PENDING), 16'h1);
    if_a.REF_ACK = 1'b1;
    step();
    chk("t4_pend30", 16'(if_a.REF_PENDING), 16'h1);
    chk("t4_req30", 16'(if_a.REF_REQ), 16'h1);
    if_a.REF_ACK = 1'b0;

    // Test 5: one-cycle RESET in WAIT_RFC restarts the whole sequence
    do_reset();
    run_to(16);
    chk("t5_cmd16", 16'(if_a.CMD), 16'h7);
    RESET = 1'b1;
    step();
    chk("t5_cke", 16'(if_a.CKE), 16'h0);
    chk("t5_cmd", 16'(if_a.CMD), 16'hF);
    chk("t5_done", 16'(if_a.INIT_DONE), 16'h0);
    chk("t5_addr", 16'(if_a.ADDR), 16'h0);
    RESET = 1'b0;
    cyc = -1;
    run_to(0);
    chk("t5_cke0", 16'(if_a.CKE), 16'h1);
    chk("t5_cmd0", 16'(if_a.CMD), 16'hF);
    run_to(9);
    chk("t5_cmd9", 16'(if_a.CMD), 16'hF);
    step();
    chk("t5_cmd10", 16'(if_a.CMD), 16'h2);
    chk("t5_addr10", 16'(if_a.ADDR), 16'h0400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
